// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the UART instruction-memory bootloader.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
  localparam logic [31:0] CPU_PERIPH_BASE = 32'h4000_0000;
  localparam int unsigned LEN_W           = 16;

endpackage

// File: rtl/loader_word_assembler.sv
// Byte-to-word assembly for the bootloader: MSB-first shift register,
// byte counter, running XOR checksum and a one-cycle word-ready strobe.
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        data_valid,
  input  logic        len_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  csum
);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  csum_q, csum_d;
  logic        word_ready_q, word_ready_d;

  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    word_ready_d = 1'b0;
    if (clear) begin
      byte_cnt_d = 2'd0;
      shift_d    = 32'd0;
      csum_d     = 8'd0;
    end else begin
      if (data_valid) begin
        shift_d      = {shift_q[23:0], rx_data};
        byte_cnt_d   = byte_cnt_q + 2'd1;
        word_ready_d = (byte_cnt_q == 2'd3);
      end
      // Length bytes and data bytes both feed the checksum; SYNC never does.
      if (data_valid || len_valid) begin
        csum_d = csum_q ^ rx_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q   <= 2'd0;
      shift_q      <= 32'd0;
      csum_q       <= 8'd0;
      word_ready_q <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
      word_ready_q <= word_ready_d;
    end
  end

  assign word       = shift_q;
  assign word_ready = word_ready_q;
  assign csum       = csum_q;

endmodule

// File: rtl/imem_uart_loader.sv
// UART bootloader: parses SYNC/LEN/data/CSUM frames, writes big-endian words
// into instruction RAM and holds the CPU in reset while the image is in flux.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 1000000,
  parameter logic [7:0]  SYNC    = SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [7:0]         len_hi_q, len_hi_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
  logic               dirty_q, dirty_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               cpu_hold_q, cpu_hold_d;
  logic               busy_q, busy_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;

  logic               timeout_c;
  logic               rx_c;
  logic               err_c;
  logic               clear_c;
  logic [LEN_W-1:0]   len_c;
  logic               wr_strobe;
  logic [31:0]        word;
  logic [7:0]         csum;

  loader_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear_c),
    .data_valid (rx_c && (state_q == ST_DATA)),
    .len_valid  (rx_c && ((state_q == ST_LEN_HI) || (state_q == ST_LEN_LO))),
    .rx_data    (rx_data),
    .word       (word),
    .word_ready (wr_strobe),
    .csum       (csum)
  );

  // A byte landing in the same cycle the timeout fires is dropped.
  assign timeout_c = (state_q != ST_IDLE) && (state_q != ST_ERR) &&
                     (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign rx_c      = rx_valid && !timeout_c;
  assign len_c     = {len_hi_q, rx_data};

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    word_idx_d  = wr_strobe ? (word_idx_q + ADDR_W'(1)) : word_idx_q;
    dirty_d     = dirty_q | wr_strobe;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    err_c       = 1'b0;
    clear_c     = 1'b0;

    if ((state_q == ST_IDLE) || (state_q == ST_ERR) || rx_valid || timeout_c) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC)) begin
          state_d    = ST_LEN_HI;
          clear_c    = 1'b1;
          load_err_d = 1'b0;
          cpu_hold_d = 1'b1;
          word_idx_d = '0;
          dirty_d    = 1'b0;
        end
      end
      ST_LEN_HI: begin
        if (rx_c) begin
          len_hi_d = rx_data;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_c) begin
          len_d = len_c;
          if (len_c > LEN_W'(DEPTH)) begin
            err_c = 1'b1;
          end else if (len_c == '0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        // Leave DATA only on the write cycle itself so imem_we stays inside DATA.
        if (wr_strobe && (LEN_W'(word_idx_q) == (len_q - LEN_W'(1)))) begin
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (rx_c) begin
          if (rx_data == csum) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
            cpu_hold_d  = 1'b0;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Keep the CPU held only if this frame already overwrote RAM.
    if (err_c || timeout_c) begin
      state_d    = ST_ERR;
      load_err_d = 1'b1;
      cpu_hold_d = dirty_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      len_hi_q    <= 8'd0;
      len_q       <= '0;
      word_idx_q  <= '0;
      dirty_q     <= 1'b0;
      to_cnt_q    <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      dirty_q     <= dirty_d;
      to_cnt_q    <= to_cnt_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign imem_we    = wr_strobe;
  assign imem_addr  = word_idx_q;
  assign imem_wdata = word;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: nominal, oversize, bad checksum,
// timeout, zero-length and mid-load asynchronous reset.
module tb_imem_uart_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        load_done;
  logic        load_err;

  int total;
  int bad;

  int          wr_cnt;
  int          done_cnt;
  logic [7:0]  wa [0:7];
  logic [31:0] wd [0:7];
  logic [7:0]  frm [0:11];

  imem_uart_loader #(
    .DEPTH   (256),
    .ADDR_W  (8),
    .TIMEOUT (100),
    .SYNC    (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 8) begin
        wa[wr_cnt] = imem_addr;
        wd[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (load_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frm(input int n);
    for (int i = 0; i < n; i++) send_byte(frm[i]);
  endtask

  task automatic clr_mon();
    @(negedge clk);
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic load_nominal(input logic [7:0] cs);
    frm[0] = 8'hA5; frm[1] = 8'h00; frm[2] = 8'h02; frm[3] = 8'h3C;
    frm[4] = 8'h10; frm[5] = 8'h40; frm[6] = 8'h00; frm[7] = 8'h20;
    frm[8] = 8'h14; frm[9] = 8'hEC; frm[10] = 8'h77; frm[11] = cs;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    wr_cnt   = 0;
    done_cnt = 0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reset    = 1'b0;
    #12;
    check_val("rst_hold", 32'(cpu_hold), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_we",   32'(imem_we), 32'd0);
    check_val("rst_addr", 32'(imem_addr), 32'd0);
    check_val("rst_wdata", imem_wdata, 32'd0);
    check_val("rst_done", 32'(load_done), 32'd0);
    check_val("rst_err",  32'(load_err), 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal two-word load, checksum 0xC1
    clr_mon();
    load_nominal(8'hC1);
    send_byte(frm[0]);
    @(negedge clk);
    check_val("nom_hold_after_sync", 32'(cpu_hold), 32'd1);
    check_val("nom_busy_after_sync", 32'(busy), 32'd1);
    for (int i = 1; i < 11; i++) send_byte(frm[i]);
    @(negedge clk);
    check_val("nom_hold_mid", 32'(cpu_hold), 32'd1);
    send_byte(frm[11]);
    @(negedge clk);
    check_val("nom_done", 32'(load_done), 32'd1);
    check_val("nom_hold_rel", 32'(cpu_hold), 32'd0);
    check_val("nom_busy_rel", 32'(busy), 32'd0);
    check_val("nom_err", 32'(load_err), 32'd0);
    @(negedge clk);
    check_val("nom_done_pulse", 32'(load_done), 32'd0);
    check_val("nom_wr_cnt", 32'(wr_cnt), 32'd2);
    check_val("nom_addr0", 32'(wa[0]), 32'd0);
    check_val("nom_data0", wd[0], 32'h3C104000);
    check_val("nom_addr1", 32'(wa[1]), 32'd1);
    check_val("nom_data1", wd[1], 32'h2014EC77);
    check_val("nom_done_cnt", 32'(done_cnt), 32'd1);

    // Oversize length 257
    clr_mon();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    check_val("ovr_err", 32'(load_err), 32'd1);
    check_val("ovr_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    check_val("ovr_idle", 32'(busy), 32'd0);
    check_val("ovr_wr_cnt", 32'(wr_cnt), 32'd0);

    // Bad checksum then recovery
    clr_mon();
    load_nominal(8'hC0);
    send_frm(12);
    @(negedge clk);
    check_val("bcs_err", 32'(load_err), 32'd1);
    check_val("bcs_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    check_val("bcs_idle", 32'(busy), 32'd0);
    check_val("bcs_hold_kept", 32'(cpu_hold), 32'd1);
    check_val("bcs_wr_cnt", 32'(wr_cnt), 32'd2);
    check_val("bcs_done_cnt", 32'(done_cnt), 32'd0);
    clr_mon();
    load_nominal(8'hC1);
    send_byte(frm[0]);
    @(negedge clk);
    check_val("rec_err_clr", 32'(load_err), 32'd0);
    for (int i = 1; i < 12; i++) send_byte(frm[i]);
    @(negedge clk);
    check_val("rec_done", 32'(load_done), 32'd1);
    check_val("rec_hold", 32'(cpu_hold), 32'd0);
    check_val("rec_err", 32'(load_err), 32'd0);
    check_val("rec_data1", wd[1], 32'h2014EC77);

    // Inter-byte timeout of 100 cycles
    clr_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h3C);
    repeat (99) @(posedge clk);
    @(negedge clk);
    check_val("to_early", 32'(load_err), 32'd0);
    check_val("to_early_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_val("to_err", 32'(load_err), 32'd1);
    check_val("to_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'h55);
    @(negedge clk);
    check_val("to_garbage_busy", 32'(busy), 32'd0);
    check_val("to_err_sticky", 32'(load_err), 32'd1);
    check_val("to_wr_cnt", 32'(wr_cnt), 32'd0);

    // Zero-length frame
    clr_mon();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check_val("zl_done", 32'(load_done), 32'd1);
    check_val("zl_hold", 32'(cpu_hold), 32'd0);
    check_val("zl_err", 32'(load_err), 32'd0);
    check_val("zl_wr_cnt", 32'(wr_cnt), 32'd0);

    // Asynchronous reset in the middle of DATA
    clr_mon();
    load_nominal(8'hC1);
    send_frm(6);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("ar_hold", 32'(cpu_hold), 32'd0);
    check_val("ar_busy", 32'(busy), 32'd0);
    check_val("ar_we", 32'(imem_we), 32'd0);
    check_val("ar_wdata", imem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    clr_mon();
    send_frm(12);
    @(negedge clk);
    check_val("ar_done", 32'(load_done), 32'd1);
    check_val("ar_wr_cnt", 32'(wr_cnt), 32'd2);
    check_val("ar_addr0", 32'(wa[0]), 32'd0);
    check_val("ar_data0", wd[0], 32'h3C104000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
